// File: rtl/buffer_wr_arbiter.sv
// buffer_wr_arbiter
//   Shares the single write port of a circular buffer between NUM_REQ
//   requesters. A round-robin burst arbiter grants one owner at a time.
//   While that owner holds its request, the block pulses the write-pointer
//   increment. The owner's data is muxed onto the RAM write bus. Accepted
//   reads pulse the read-pointer increment. A registered occupancy count
//   produces the full and empty flags.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_req        per-requester write request (level)
//   i_wr_data_in packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_rd_req     consumer read request (level)
//   o_gnt        registered one-hot grant, 0 while idle
//   o_wr_cnt     write-pointer increment / RAM write enable
//   o_wr_data    data slice of the current owner
//   o_rd_cnt     read-pointer increment (read accepted)
//   o_occupancy  words stored, 0..DEPTH
//   o_full       occupancy == DEPTH
//   o_empty      occupancy == 0
module buffer_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wr_data_in,
  input  logic                          i_rd_req,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_wr_cnt,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic                          o_rd_cnt,
  output logic [ADDR_WIDTH:0]           o_occupancy,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int OW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  r_state;
  logic [OW-1:0]           r_owner;
  logic [OW-1:0]           r_rr_ptr;
  logic [BW-1:0]           r_burst_cnt;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [ADDR_WIDTH:0]     r_occ;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_din;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_found;
  logic [OW-1:0]           w_win;
  logic [OW:0]             w_idx;
  logic [OW-1:0]           w_owner_nxt;

  assign w_din   = i_wr_data_in;
  assign w_full  = (r_occ == (ADDR_WIDTH+1)'(DEPTH));
  assign w_empty = (r_occ == '0);

  // Both flags come from the registered count. A write while full stalls
  // even if a read frees a slot in the same cycle.
  assign w_wr = (r_state == BURST) & i_req[r_owner] & ~w_full;
  assign w_rd = i_rd_req & ~w_empty;

  // Pick the first requester at or above rr_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (OW+1)'(k);
      if (w_idx >= (OW+1)'(NUM_REQ)) w_idx = w_idx - (OW+1)'(NUM_REQ);
      if (!w_found && i_req[w_idx[OW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[OW-1:0];
      end
    end
  end

  assign w_owner_nxt = (r_owner == OW'(NUM_REQ-1)) ? '0 : r_owner + OW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_gnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state     <= BURST;
            r_owner     <= w_win;
            r_gnt       <= NUM_REQ'(1) << w_win;
            r_burst_cnt <= '0;
          end
        end
        BURST: begin
          // Stalled cycles leave burst_cnt untouched.
          if (!i_req[r_owner] || (w_wr && r_burst_cnt == BW'(MAX_BURST-1))) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= w_owner_nxt;
          end else if (w_wr) begin
            r_burst_cnt <= r_burst_cnt + BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_occ <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_occ <= r_occ + (ADDR_WIDTH+1)'(1);
        2'b01:   r_occ <= r_occ - (ADDR_WIDTH+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_wr_cnt    = w_wr;
  assign o_wr_data   = w_din[r_owner];
  assign o_rd_cnt    = w_rd;
  assign o_occupancy = r_occ;
  assign o_full      = w_full;
  assign o_empty     = w_empty;

endmodule
